// File: rtl/fifo_tx_pkg.sv
// Shared types and defaults for the FIFO-draining serial transmitter.
package fifo_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_t;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_WIDTH   = 5;
  localparam int DEF_PARITY_EN    = 0;
  localparam int DEF_STOP_BITS    = 1;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/fifo_serial_tx_bit_timer.sv
// Free-running bit-period down-counter; start reloads it so a bit begins on a clean boundary.
module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic tick,
  output logic near_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TOP = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Reload on start or when a bit period expires, otherwise count down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= CNT_W'(0);
    end else if (start || (cnt == CNT_W'(0))) begin
      cnt <= TOP;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // tick marks the last cycle of a bit; near_tick the cycle before it.
  assign tick      = (cnt == CNT_W'(0));
  assign near_tick = (cnt == CNT_W'(1));

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from a FIFO and sends each as an async serial frame: start, data LSB first,
// optional even parity, then 1 or 2 stop bits.
module fifo_serial_tx
  import fifo_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int PARITY_EN    = DEF_PARITY_EN,
  parameter int STOP_BITS    = DEF_STOP_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [IDX_W-1:0]      bit_idx;
  logic                  stop_idx;
  logic                  parity_acc;
  logic                  timer_start;
  logic                  tick;
  logic                  near_tick;
  logic                  fetch_ok;
  logic                  last_stop;

  assign fetch_ok    = enable && !fifo_empty;
  assign last_stop   = (STOP_BITS == 1) || stop_idx;
  // The timer is realigned while loading so the start bit gets a full period.
  assign timer_start = (state == LOAD);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .start     (timer_start),
    .tick      (tick),
    .near_tick (near_tick)
  );

  // Frame sequencer; all outputs are registered so tx cannot glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_idx    <= IDX_W'(0);
      stop_idx   <= 1'b0;
      parity_acc <= 1'b0;
      tx         <= IDLE_LEVEL;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_ok) begin
            state      <= FETCH;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          shreg      <= fifo_data;
          parity_acc <= 1'b0;
          bit_idx    <= IDX_W'(0);
          stop_idx   <= 1'b0;
          tx         <= START_LEVEL;
          state      <= START;
        end
        START: begin
          if (tick) begin
            tx         <= shreg[0];
            parity_acc <= parity_acc ^ shreg[0];
            shreg      <= shreg >> 1;
            state      <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_IDX) begin
              if (PARITY_EN != 0) begin
                tx    <= parity_acc;
                state <= PARITY;
              end else begin
                tx    <= IDLE_LEVEL;
                state <= STOP;
              end
            end else begin
              bit_idx    <= bit_idx + IDX_W'(1);
              tx         <= shreg[0];
              parity_acc <= parity_acc ^ shreg[0];
              shreg      <= shreg >> 1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx    <= IDLE_LEVEL;
            state <= STOP;
          end
        end
        STOP: begin
          if (near_tick && last_stop) begin
            frame_done <= 1'b1;
          end
          // The FIFO is only looked at here and in IDLE, so an empty FIFO is never popped.
          if (tick) begin
            if (!last_stop) begin
              stop_idx <= 1'b1;
            end else if (fetch_ok) begin
              fifo_rd_en <= 1'b1;
              state      <= FETCH;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          tx    <= IDLE_LEVEL;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench: three transmitter configurations, each fed by a small FIFO model.
module tb_fifo_serial_tx;

  logic       clk;
  logic       rst;
  logic       fifo_clr;
  logic [2:0] en;
  logic [2:0] empty;
  logic [2:0] rd;
  logic [2:0] tx;
  logic [2:0] busy;
  logic [2:0] fd;
  logic [4:0] dout [3];
  logic [4:0] mem  [3][16];
  logic [3:0] wp   [3];
  logic [3:0] rp   [3];
  int         pops [3];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         inst;
    logic [4:0] word;
    logic [15:0] bits;
    int         nbits;
  } vec_t;

  vec_t vecs [7];

  fifo_serial_tx u_def (
    .clk(clk), .rst(rst), .enable(en[0]), .fifo_empty(empty[0]), .fifo_data(dout[0]),
    .fifo_rd_en(rd[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(fd[0])
  );

  fifo_serial_tx #(.PARITY_EN(1), .STOP_BITS(2)) u_par (
    .clk(clk), .rst(rst), .enable(en[1]), .fifo_empty(empty[1]), .fifo_data(dout[1]),
    .fifo_rd_en(rd[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(fd[1])
  );

  fifo_serial_tx #(.CLKS_PER_BIT(2)) u_fast (
    .clk(clk), .rst(rst), .enable(en[2]), .fifo_empty(empty[2]), .fifo_data(dout[2]),
    .fifo_rd_en(rd[2]), .tx(tx[2]), .busy(busy[2]), .frame_done(fd[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 3; i++) empty[i] = (wp[i] == rp[i]);
  end

  // FIFO read side: data appears the cycle after the pop.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (fifo_clr) begin
        rp[i]   <= 4'd0;
        pops[i] <= 0;
        dout[i] <= 5'd0;
      end else if (rd[i]) begin
        dout[i] <= mem[i][rp[i]];
        rp[i]   <= rp[i] + 4'd1;
        pops[i] <= pops[i] + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [4:0] w);
    mem[i][wp[i]] = w;
    wp[i] = wp[i] + 4'd1;
  endtask

  // Count negedges until tx falls; tx must stay high while waiting.
  task automatic wait_fall(input int i, input int exp_steps);
    int steps = 0;
    do begin
      @(negedge clk);
      steps++;
    end while (tx[i] !== 1'b0 && steps < 60);
    chk("start latency", steps, exp_steps);
  endtask

  // Called on the first low cycle of the start bit; walks the whole frame.
  task automatic check_frame(input int i, input logic [15:0] bits, input int nbits, input int drop_at);
    int cpb = (i == 2) ? 2 : 16;
    int len = nbits * cpb;
    int bad = 0;
    int fd_bad = 0;
    int busy_bad = 0;
    for (int n = 0; n < len; n++) begin
      if (n > 0) @(negedge clk);
      if (n == drop_at) en[i] = 1'b0;
      if (tx[i] !== bits[n / cpb]) bad++;
      if (fd[i] !== (n == len - 1)) fd_bad++;
      if (busy[i] !== 1'b1) busy_bad++;
      if ((n % cpb) == cpb - 1) begin
        chk($sformatf("frame bit %0d wrong cycles", n / cpb), bad, 0);
        bad = 0;
      end
    end
    chk("frame_done placement errors", fd_bad, 0);
    chk("busy low during frame", busy_bad, 0);
  endtask

  initial begin
    int p0;
    int errs;
    vecs[0] = '{0, 5'h15, 16'h006A, 7};
    vecs[1] = '{0, 5'h00, 16'h0040, 7};
    vecs[2] = '{1, 5'h07, 16'h01CE, 9};
    vecs[3] = '{1, 5'h15, 16'h01EA, 9};
    vecs[4] = '{1, 5'h03, 16'h0186, 9};
    vecs[5] = '{2, 5'h15, 16'h006A, 7};
    vecs[6] = '{2, 5'h0A, 16'h0054, 7};

    rst = 1'b1;
    fifo_clr = 1'b1;
    en = 3'b111;
    for (int i = 0; i < 3; i++) wp[i] = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset tx", {29'd0, tx}, 32'h7);
    chk("reset fifo_rd_en", {29'd0, rd}, 32'h0);
    chk("reset busy", {29'd0, busy}, 32'h0);
    chk("reset frame_done", {29'd0, fd}, 32'h0);
    rst = 1'b0;
    fifo_clr = 1'b0;

    // Single frames from idle across all three configurations.
    for (int v = 0; v < 7; v++) begin
      repeat (4) @(negedge clk);
      p0 = pops[vecs[v].inst];
      push(vecs[v].inst, vecs[v].word);
      wait_fall(vecs[v].inst, 3);
      check_frame(vecs[v].inst, vecs[v].bits, vecs[v].nbits, -1);
      chk("pops per frame", pops[vecs[v].inst] - p0, 1);
      chk("fifo empty after frame", {31'd0, empty[vecs[v].inst]}, 32'h1);
    end

    // Three queued words go out back to back with two idle-level cycles between frames.
    repeat (4) @(negedge clk);
    p0 = pops[0];
    push(0, 5'h00);
    push(0, 5'h1F);
    push(0, 5'h0A);
    wait_fall(0, 3);
    check_frame(0, 16'h0040, 7, -1);
    wait_fall(0, 3);
    check_frame(0, 16'h007E, 7, -1);
    wait_fall(0, 3);
    check_frame(0, 16'h0054, 7, -1);
    repeat (3) @(negedge clk);
    chk("b2b pop count", pops[0] - p0, 3);
    chk("b2b fifo empty", {31'd0, empty[0]}, 32'h1);
    chk("b2b idle busy", {31'd0, busy[0]}, 32'h0);

    // Disabled block leaves a non-empty FIFO alone; dropping enable mid-frame stops further pops.
    en[0] = 1'b0;
    p0 = pops[0];
    push(0, 5'h1F);
    push(0, 5'h0A);
    errs = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rd[0] !== 1'b0 || tx[0] !== 1'b1) errs++;
    end
    chk("disabled activity", errs, 0);
    en[0] = 1'b1;
    wait_fall(0, 3);
    check_frame(0, 16'h007E, 7, 30);
    errs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rd[0] !== 1'b0 || tx[0] !== 1'b1 || busy[0] !== 1'b0) errs++;
    end
    chk("activity after enable drop", errs, 0);
    chk("pops after enable drop", pops[0] - p0, 1);
    chk("word left in fifo", {31'd0, empty[0]}, 32'h0);
    en[0] = 1'b1;
    wait_fall(0, 3);
    check_frame(0, 16'h0054, 7, -1);

    // Asynchronous reset during data bit 3 forces the line idle at once.
    repeat (4) @(negedge clk);
    push(0, 5'h15);
    wait_fall(0, 3);
    repeat (4 * 16 + 5) @(negedge clk);
    chk("tx during data bit 3", {31'd0, tx[0]}, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("tx right after async reset", {31'd0, tx[0]}, 32'h1);
    chk("busy right after async reset", {31'd0, busy[0]}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    errs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || rd[0] !== 1'b0 || busy[0] !== 1'b0 || fd[0] !== 1'b0) errs++;
    end
    chk("idle after reset release", errs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_serial_tx.md
# fifo_serial_tx

Serial transmitter that drains the 5-bit word FIFO from its read side and sends each word as an asynchronous serial frame on a single line. The block drives the FIFO's `rd_en` and consumes its `empty` and `data_out`, so words queued by an upstream writer leave the chip one frame at a time. It sits directly after the FIFO in the outbound datapath.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal values are 2 and above.
- `DATA_WIDTH`, 5: payload bits per frame; must match the FIFO word width.
- `PARITY_EN`, 0: when 1, an even-parity bit is sent after the data bits.
- `STOP_BITS`, 1: number of stop bits; legal values are 1 or 2.

- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  reset; asynchronous, active-high.
- `enable`  in  1  when high, the block may fetch new words.
- `fifo_empty`  in  1  the FIFO's `empty` output.
- `fifo_data`  in  DATA_WIDTH  the FIFO's `data_out`; valid the cycle after a pop.
- `fifo_rd_en`  out  1  pop strobe to the FIFO; high for exactly one cycle per word.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse on the last cycle of the final stop bit.

## Operation
- Reset values: `tx`=1, `fifo_rd_en`=0, `busy`=0, `frame_done`=0, state=IDLE, all counters 0, shift register 0. Reset takes effect asynchronously, including in the middle of a frame. `tx` returns high immediately and the word in flight is lost.
- FSM states: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
  - IDLE: if `enable` is high and `fifo_empty` is low, go to FETCH. Otherwise stay.
  - FETCH: one cycle. `fifo_rd_en` is 1, decoded from the state register with no combinational path from inputs. Go to LOAD.
  - LOAD: one cycle. Capture `fifo_data` into the shift register and initialise the parity accumulator. Go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles. Then go to DATA.
  - DATA: send DATA_WIDTH bits, LSB first, each held for CLKS_PER_BIT cycles. Then go to PARITY if PARITY_EN is 1, otherwise go to STOP.
  - PARITY: `tx` carries the XOR of the data bits for CLKS_PER_BIT cycles. Then go to STOP.
  - STOP: `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles, and `frame_done` pulses on the final cycle. If `enable` is high and `fifo_empty` is low, go to FETCH. Otherwise go to IDLE.
- `enable` falling mid-frame: the current frame completes normally and no further fetch occurs.
- `fifo_empty` is sampled only in IDLE and on the final STOP cycle, so the block never pops an empty FIFO.
- The bit-cycle counter is $clog2(CLKS_PER_BIT) bits wide and wraps from CLKS_PER_BIT-1 to 0. The bit index is $clog2(DATA_WIDTH) bits wide.
- `tx` is driven from a register and must be glitch-free.

## Timing
- Latency: `fifo_empty` is sampled low in IDLE at cycle 0. `fifo_rd_en` is high in cycle 1. Data is captured in cycle 2. `tx` falls in cycle 3.
- Frame length: (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles. With defaults this is 7×16 = 112 cycles.
- Back-to-back frames: exactly 2 cycles of `tx`=1 (FETCH and LOAD) between the end of one stop bit and the next start bit.
- Word throughput with defaults is one word per 114 cycles. The upstream writer must not exceed this rate sustained.

## Structure
- Package `fifo_tx_pkg` holds:
  - the `tx_state_t` enum;
  - defaults for CLKS_PER_BIT, DATA_WIDTH, PARITY_EN and STOP_BITS;
  - the line levels IDLE_LEVEL=1 and START_LEVEL=0.
- Sub-module `bit_timer`: a parameterised CLKS_PER_BIT down-counter with `start` and `tick` ports, reset asynchronously. The FSM advances bits on `tick`.

## Test plan
- Reset, then push 5'h15 with defaults: `fifo_rd_en` pulses once, then `tx` carries 0 for 16 cycles, bits 1,0,1,0,1 for 16 cycles each, then 1 for 16 cycles. `frame_done` pulses at the end.
- Push 5'h00, 5'h1F, 5'h0A together: three frames, each separated by exactly 2 high cycles, exactly three `fifo_rd_en` pulses, and `fifo_empty` high at the end.
- PARITY_EN=1, STOP_BITS=2, word 5'h07: parity bit is 1, stop is high for 32 cycles, and the frame is 144 cycles long.
- Assert `rst` during bit 3 of the DATA state: `tx`=1 and `busy`=0 in the same cycle. With the FIFO empty after release, `tx` stays idle.
- `enable`=0 with the FIFO non-empty: no `fifo_rd_en` and `tx` stays 1. Raise `enable`: the frame starts 3 cycles later. Drop `enable` mid-frame: the frame finishes and no next pop occurs.
- CLKS_PER_BIT=2: every bit lasts exactly 2 cycles and the frame is 14 cycles.
